// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button level in, conditioned press/level/long-press out
interface button_conditioner_if;
   logic sButton_raw;
   logic sButton;
   logic sPressed;
   logic sLong;

   // master drives the raw button and observes the conditioned outputs
   modport master (
      output sButton_raw,
      input  sButton,
      input  sPressed,
      input  sLong
   );

   // slave is the conditioner itself
   modport slave (
      input  sButton_raw,
      output sButton,
      output sPressed,
      output sLong
   );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and classify a mechanical push button
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LONG_CYCLES     = 16
) (
   input logic                 sClk,
   input logic                 sReset,
   button_conditioner_if.slave btn
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      HELD,
      RELEASE_WAIT
   } state_t;

   // Terminal counts; cnt never passes these, so 8 bits cannot wrap.
   localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] LONG_LAST = 8'(LONG_CYCLES - 1);

   logic       sync1_q;
   logic       sync_q;
   state_t     state_q;
   logic [7:0] cnt_q;
   logic       button_q;
   logic       pressed_q;
   logic       long_q;

   // Two-flop synchronizer; only sync_q is allowed into the FSM.
   always_ff @(posedge sClk) begin
      if (!sReset) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         sync1_q <= btn.sButton_raw;
         sync_q  <= sync1_q;
      end
   end

   // Debounce FSM with registered pulse and level outputs.
   always_ff @(posedge sClk) begin
      if (!sReset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         button_q  <= 1'b0;
         pressed_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         // Pulses are single-cycle unless a branch below re-asserts them.
         button_q <= 1'b0;
         long_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sync_q) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= 8'd1;
               end else begin
                  cnt_q <= 8'd0;
               end
            end
            PRESS_WAIT: begin
               if (!sync_q) begin
                  // Too short to be a press: drop it silently.
                  state_q <= IDLE;
                  cnt_q   <= 8'd0;
               end else if (cnt_q == DB_LAST) begin
                  state_q   <= PRESSED;
                  pressed_q <= 1'b1;
                  button_q  <= 1'b1;
                  cnt_q     <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            PRESSED: begin
               if (!sync_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= 8'd1;
               end else if (cnt_q == LONG_LAST) begin
                  state_q <= HELD;
                  long_q  <= 1'b1;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            HELD: begin
               if (!sync_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= 8'd1;
               end else begin
                  cnt_q <= 8'd0;
               end
            end
            RELEASE_WAIT: begin
               if (sync_q) begin
                  // Release bounce: keep the press but never fire sLong for it.
                  state_q <= HELD;
                  cnt_q   <= 8'd0;
               end else if (cnt_q == DB_LAST) begin
                  state_q   <= IDLE;
                  pressed_q <= 1'b0;
                  cnt_q     <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q   <= IDLE;
               cnt_q     <= 8'd0;
               pressed_q <= 1'b0;
            end
         endcase
      end
   end

   assign btn.sButton  = button_q;
   assign btn.sPressed = pressed_q;
   assign btn.sLong    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
   localparam int D = 4;
   localparam int L = 16;

   logic sClk = 1'b0;
   logic sReset;

   button_conditioner_if bif ();

   button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES(L)
   ) dut (
      .sClk(sClk),
      .sReset(sReset),
      .btn(bif.slave)
   );

   always #5 sClk = ~sClk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: run lengths of the synchronized level
   bit m_s1, m_s2;
   int ones, zeros;
   bit m_pressed, m_long_ok;
   bit exp_btn, exp_long;
   bit prev_btn, prev_long;

   typedef struct {
      logic [63:0] bits;
      int          len;
      int          n_btn;
      int          n_long;
      int          btn_at;
      int          long_at;
      int          rel_at;
      bit          pressed_end;
   } scen_t;

   scen_t tbl[5];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst_n, input bit raw);
      bit seen;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; ones = 0; zeros = 0;
         m_pressed = 0; m_long_ok = 0; exp_btn = 0; exp_long = 0;
      end else begin
         seen = m_s2;
         exp_btn = 0;
         exp_long = 0;
         if (seen) begin
            ones++;
            zeros = 0;
         end else begin
            zeros++;
            ones = 0;
            m_long_ok = 0;
         end
         if (!m_pressed && ones == D) begin
            m_pressed = 1; exp_btn = 1; m_long_ok = 1;
         end else if (m_pressed && m_long_ok && ones == D + L) begin
            exp_long = 1; m_long_ok = 0;
         end else if (m_pressed && zeros == D) begin
            m_pressed = 0;
         end
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   task automatic step(input bit rst_n, input bit raw);
      @(negedge sClk);
      sReset = rst_n;
      bif.sButton_raw = raw;
      @(posedge sClk);
      model_edge(rst_n, raw);
      #1;
      check("sButton", int'(bif.sButton), int'(exp_btn));
      check("sPressed", int'(bif.sPressed), int'(m_pressed));
      check("sLong", int'(bif.sLong), int'(exp_long));
      check("overlap", int'(bif.sButton & bif.sLong), 0);
      check("btn_single", int'(bif.sButton & prev_btn), 0);
      check("long_single", int'(bif.sLong & prev_long), 0);
      prev_btn = bif.sButton;
      prev_long = bif.sLong;
   endtask

   task automatic run_scen(input int id);
      logic [63:0] b;
      int nb, nl, first_b, first_l, rel;
      bit was_p, pend, raw;
      b = tbl[id].bits;
      nb = 0; nl = 0; first_b = -1; first_l = -1; rel = -1; was_p = 0; pend = 0;
      step(0, 0);
      step(0, 0);
      for (int i = 0; i < tbl[id].len + 12; i++) begin
         raw = (i < tbl[id].len) ? b[i] : 1'b0;
         step(1, raw);
         if (bif.sButton) begin
            nb++;
            if (first_b < 0) first_b = i;
         end
         if (bif.sLong) begin
            nl++;
            if (first_l < 0) first_l = i;
         end
         if (was_p && !bif.sPressed && rel < 0) rel = i;
         was_p = bif.sPressed;
         if (i == tbl[id].len - 1) pend = bif.sPressed;
      end
      check($sformatf("scen%0d_btn_count", id), nb, tbl[id].n_btn);
      check($sformatf("scen%0d_long_count", id), nl, tbl[id].n_long);
      check($sformatf("scen%0d_btn_cycle", id), first_b, tbl[id].btn_at);
      check($sformatf("scen%0d_long_cycle", id), first_l, tbl[id].long_at);
      check($sformatf("scen%0d_release_cycle", id), rel, tbl[id].rel_at);
      check($sformatf("scen%0d_pressed_end", id), int'(pend), int'(tbl[id].pressed_end));
   endtask

   initial begin
      int nb, first_b, cyc, run_len;
      bit lvl, rst_n;

      // bits, len, n_btn, n_long, btn_at, long_at, rel_at, pressed_end
      tbl[0] = '{64'h3FFF_FFFF, 30, 1, 1, 5, 21, 35, 1'b1};  // clean press, long
      tbl[1] = '{64'h7,         10, 0, 0, -1, -1, -1, 1'b0}; // 3-cycle glitch
      tbl[2] = '{64'hF_FFF5,    20, 1, 0, 9, -1, 25, 1'b1};  // bouncy press
      tbl[3] = '{64'h2FF,       20, 1, 0, 5, -1, 15, 1'b0};  // short press, release bounce
      tbl[4] = '{64'h1FFF_FEFF, 29, 1, 0, 5, -1, 34, 1'b1};  // bounce then hold: sLong suppressed

      prev_btn = 0;
      prev_long = 0;
      sReset = 1'b0;
      bif.sButton_raw = 1'b0;

      // Reset state, with raw high to show reset dominates
      step(0, 1);
      step(0, 1);
      check("reset_sButton", int'(bif.sButton), 0);
      check("reset_sPressed", int'(bif.sPressed), 0);
      check("reset_sLong", int'(bif.sLong), 0);

      for (int s = 0; s < 5; s++) run_scen(s);

      // Reset mid-press with raw still held
      step(0, 0);
      step(0, 0);
      for (int i = 0; i < 8; i++) step(1, 1);
      check("midpress_pressed_before", int'(bif.sPressed), 1);
      for (int i = 0; i < 2; i++) begin
         step(0, 1);
         check("midrst_sButton", int'(bif.sButton), 0);
         check("midrst_sPressed", int'(bif.sPressed), 0);
         check("midrst_sLong", int'(bif.sLong), 0);
      end
      nb = 0;
      first_b = -1;
      for (int i = 0; i < 12; i++) begin
         step(1, 1);
         if (bif.sButton) begin
            nb++;
            if (first_b < 0) first_b = i;
         end
      end
      check("midrst_new_btn_count", nb, 1);
      check("midrst_new_btn_cycle", first_b, 5);

      // Randomized runs of random length, occasional resets, against the model
      cyc = 0;
      while (cyc < 4000) begin
         lvl = 1'($urandom_range(0, 1));
         run_len = $urandom_range(1, 26);
         for (int i = 0; i < run_len; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step(rst_n, lvl);
            cyc++;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
